// File: rtl/cpu_pkg.sv
// cpu_pkg: shared MEM-stage controller types and defaults.
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } mem_ctrl_state_t;
    localparam int MEM_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences req/ack data-memory accesses and stalls the pipeline until each completes.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        wb_bubble,
    output logic [31:0] load_data,
    output logic        busy,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    mem_ctrl_state_t state;
    logic [CW-1:0] cnt;
    logic mem_op;
    logic timeout;
    assign mem_op  = ex_memRead | ex_memWrite;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    // The IDLE cycle that launches an access already stalls, so the op stays in MEM.
    always_comb begin
        stall     = rst ? 1'b0 : state == BUSY ? 1'b1 : state == IDLE ? mem_op : 1'b0;
        wb_bubble = stall;
        dmem_req  = state == BUSY;
        busy      = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mem_op) begin
                    dmem_addr  <= ex_addr;
                    dmem_wdata <= ex_wdata;
                    dmem_we    <= ex_memWrite;
                    cnt        <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_ack) begin
                        if (!dmem_we) load_data <= dmem_rdata;
                        state <= RELEASE;
                    end else if (timeout) begin
                        mem_err <= 1'b1;
                        if (!dmem_we) load_data <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: vector table, corner sequences and random ops against a transaction-level model.
module tb_mem_stage_ctrl;
    localparam int T = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_memRead = 1'b0;
    logic        ex_memWrite = 1'b0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall;
    logic        wb_bubble;
    logic [31:0] load_data;
    logic        busy;
    logic        mem_err;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_req = 0;
    int last_req = 0;
    logic [31:0] exp_load = '0;
    logic        exp_err = 1'b0;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          dly;
        int          stalls;
        logic [31:0] load;
        logic        err;
    } vec_t;
    vec_t vecs[10];
    mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_bubble(wb_bubble),
        .load_data(load_data), .busy(busy), .mem_err(mem_err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // dly: BUSY-cycle index carrying the ack, negative (or >= T) means no ack at all.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdat, input int dly, input logic spur, input int exp_stalls);
        int stalls = 0;
        int nb;
        logic mo = rd | wr;
        logic timed = !(dly >= 0 && dly < T);
        ex_memRead = rd;
        ex_memWrite = wr;
        ex_addr = addr;
        ex_wdata = wd;
        @(negedge clk);
        chk1("idle_stall", stall, mo);
        chk1("idle_bubble", wb_bubble, mo);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_req", dmem_req, 1'b0);
        stalls += int'(stall);
        tick();
        if (mo) begin
            nb = timed ? T : dly + 1;
            for (int i = 0; i < nb; i++) begin
                ex_addr = $urandom;
                ex_wdata = $urandom;
                dmem_ack = (i == dly);
                dmem_rdata = (i == dly) ? rdat : $urandom;
                @(negedge clk);
                if (i == 0) first_req = cyc;
                last_req = cyc;
                chk1("busy_req", dmem_req, 1'b1);
                chk1("busy_stall", stall, 1'b1);
                chk1("busy_bubble", wb_bubble, 1'b1);
                chk1("busy_flag", busy, 1'b1);
                chk1("busy_we", dmem_we, wr);
                chk32("busy_addr", dmem_addr, addr);
                chk32("busy_wdata", dmem_wdata, wd);
                stalls += int'(stall);
                tick();
            end
            dmem_ack = spur;
            dmem_rdata = $urandom;
            if (rd && !wr) exp_load = timed ? 32'h0 : rdat;
            if (timed) exp_err = 1'b1;
            @(negedge clk);
            chk1("rel_req", dmem_req, 1'b0);
            chk1("rel_stall", stall, 1'b0);
            chk1("rel_bubble", wb_bubble, 1'b0);
            chk1("rel_busy", busy, 1'b1);
            chk32("rel_load", load_data, exp_load);
            chk1("rel_err", mem_err, exp_err);
            stalls += int'(stall);
            ex_memRead = 1'b0;
            ex_memWrite = 1'b0;
            tick();
            dmem_ack = 1'b0;
        end
        ex_memRead = 1'b0;
        ex_memWrite = 1'b0;
        chk32("stall_cycles", 32'(stalls), 32'(exp_stalls));
    endtask
    initial begin
        int lr;
        int kind;
        int dly;
        logic rd;
        logic wr;
        vecs[0] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h80, 32'h12345678, 32'h5555AAAA, 3, 5, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h10, 32'h1, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h14, 32'h2, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h18, 32'h3, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h1C, 32'h4, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h20, 32'h5, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0BADF00D, 1, 3, 32'h0BADF00D, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'h104, 32'hA5A5A5A5, 32'h11111111, 0, 2, 32'h0BADF00D, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 32'h108, 32'h0, 32'h77777777, -1, T + 1, 32'h0, 1'b1};
        ex_memRead = 1'b1;
        ex_addr = 32'hFFFF_0000;
        repeat (2) tick();
        @(negedge clk);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_bubble", wb_bubble, 1'b0);
        tick();
        rst = 1'b0;
        ex_memRead = 1'b0;
        @(negedge clk);
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_we", dmem_we, 1'b0);
        chk32("rst_addr", dmem_addr, 32'h0);
        chk32("rst_wdata", dmem_wdata, 32'h0);
        chk32("rst_load", load_data, 32'h0);
        chk1("rst_err", mem_err, 1'b0);
        tick();
        foreach (vecs[k]) begin
            do_op(vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wd, vecs[k].rdat, vecs[k].dly, 1'b0, vecs[k].stalls);
            @(negedge clk);
            chk32("vec_load", load_data, vecs[k].load);
            chk1("vec_err", mem_err, vecs[k].err);
            chk1("vec_busy", busy, 1'b0);
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFEEDFACE;
        @(negedge clk);
        chk1("late_ack_req", dmem_req, 1'b0);
        chk1("late_ack_busy", busy, 1'b0);
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk32("late_ack_load", load_data, 32'h0);
        chk1("late_ack_err", mem_err, 1'b1);
        tick();
        do_op(1'b1, 1'b0, 32'h200, 32'h0, 32'hAAAA0001, 0, 1'b0, 2);
        lr = last_req;
        do_op(1'b1, 1'b0, 32'h204, 32'h0, 32'hAAAA0002, 0, 1'b0, 2);
        chk32("b2b_gap", 32'(first_req - lr), 32'd3);
        chk32("b2b_load", load_data, 32'hAAAA0002);
        ex_memRead = 1'b1;
        ex_addr = 32'h300;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_req_held", dmem_req, 1'b1);
        chk1("mid_rst_stall", stall, 1'b0);
        tick();
        rst = 1'b0;
        ex_memRead = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h99999999;
        @(negedge clk);
        chk1("mid_rst_req", dmem_req, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk32("mid_rst_load", load_data, 32'h0);
        chk1("mid_rst_err", mem_err, 1'b0);
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        chk32("mid_rst_ack_ignored", load_data, 32'h0);
        chk1("mid_rst_idle", busy, 1'b0);
        tick();
        exp_load = '0;
        exp_err = 1'b0;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            rd = kind == 1 || kind == 3;
            wr = kind >= 2;
            dly = $urandom_range(0, T);
            if (dly == T) dly = -1;
            do_op(rd, wr, $urandom, $urandom, $urandom, dly, 1'($urandom_range(0, 1)),
                  (rd | wr) ? 1 + ((dly < 0) ? T : dly + 1) : 0);
        end
        @(negedge clk);
        chk32("final_load", load_data, exp_load);
        chk1("final_err", mem_err, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencer for the MEM stage of the CPU pipeline: issues data-memory transactions over a variable-latency req/ack port and freezes the upstream pipeline until each access completes. While an access is outstanding it injects bubbles into the mem_wb register, and it releases the captured load data in the cycle the pipeline advances. A timeout watchdog flags a data memory that never acknowledges.

## Interface
- TIMEOUT_CYCLES, 16: maximum BUSY cycles awaiting dmem_ack before abort; must be ≥2
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- ex_memRead  in  1  instruction currently in MEM (from ex_mem) is a load
- ex_memWrite  in  1  instruction currently in MEM is a store
- ex_addr  in  32  byte address computed in EX
- ex_wdata  in  32  store data
- dmem_req  out  1  transaction request, held until ack or timeout
- dmem_we  out  1  1 = write, 0 = read; valid with dmem_req
- dmem_addr  out  32  address; stable while dmem_req=1
- dmem_wdata  out  32  write data; stable while dmem_req=1
- dmem_ack  in  1  one-cycle completion strobe
- dmem_rdata  in  32  read data; valid with dmem_ack
- stall  out  1  freeze PC, if_id, id_ex, ex_mem
- wb_bubble  out  1  force regWrite_in/memRead_in to 0 into mem_wb
- load_data  out  32  captured read data, drives mem_wb mem_data_in
- busy  out  1  state ≠ IDLE
- mem_err  out  1  sticky timeout flag, cleared only by rst

## Operation
- mem_op = ex_memRead | ex_memWrite; both set → treated as write
- States IDLE, BUSY, RELEASE (registered)
- IDLE: stall = wb_bubble = mem_op (combinational). If mem_op: latch ex_addr, ex_wdata, ex_memWrite into dmem_addr/dmem_wdata/dmem_we; clear counter; → BUSY. Else stay; instruction passes with no stall.
- BUSY: dmem_req=1, stall=wb_bubble=1, counter increments each cycle.
  - dmem_ack: if read, load_data ← dmem_rdata; → RELEASE.
  - no ack and counter = TIMEOUT_CYCLES-1: mem_err ← 1, load_data ← 0 for reads; → RELEASE.
- RELEASE: stall=wb_bubble=0, dmem_req=0; pipeline advances, mem_wb captures load_data; → IDLE unconditionally (next instruction evaluated in IDLE next cycle).
- Writes never modify load_data.
- dmem_ack in IDLE or RELEASE is ignored.
- Ack and timeout in same cycle: ack wins, mem_err unchanged.
- Counter width $clog2(TIMEOUT_CYCLES)+1; no wrap possible inside BUSY.

## Timing
- Reset (synchronous, sampled on clk rising edge): state IDLE, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, load_data 0, mem_err 0, busy 0, counter 0; stall and wb_bubble forced 0 while rst=1.
- Reset mid-transaction: dmem_req drops in the cycle after the rst edge; late ack afterwards ignored.
- Memory op with ack in first BUSY cycle: 3 cycles in MEM (IDLE-stalled, BUSY, RELEASE) = 2 stall cycles; each extra ack-wait cycle adds one.
- Non-memory op: 0 stall cycles.
- Back-to-back memory ops: RELEASE → IDLE → BUSY; minimum 3 cycles per op.
- load_data stable from the edge after ack through RELEASE and until the next read ack.
- Timeout: mem_err visible the cycle after TIMEOUT_CYCLES BUSY cycles; total stall TIMEOUT_CYCLES+1.

## Structure
- cpu_pkg: mem_ctrl_state_t enum {IDLE, BUSY, RELEASE}; MEM_TIMEOUT_DEFAULT constant.
- Single module; no sub-module (counter and FSM inline).

## Test plan
- Load, addr 0x0000_0040, ack 1st BUSY cycle, rdata 0xDEAD_BEEF → stall high 2 cycles, dmem_req 1 cycle, load_data=0xDEAD_BEEF in RELEASE, stall 0 there.
- Store, addr 0x80, wdata 0x1234_5678, ack after 4 BUSY cycles → dmem_we=1, addr/wdata stable all 4 cycles, 5 stall cycles, load_data unchanged.
- ALU op (both mem flags 0) stream of 5 → stall never asserted, busy 0, dmem_req 0.
- TIMEOUT_CYCLES=4, load, never ack → 4 BUSY cycles, mem_err=1 and stays 1, load_data=0, stall releases; later ack ignored.
- Two loads back-to-back, each ack 1st cycle → requests separated by exactly 2 idle cycles, load_data updates per load.
- rst=1 in 2nd BUSY cycle, then ack → dmem_req 0 next cycle, state IDLE, load_data 0, ack ignored.
